// File: rtl/alu_arb.sv
// Two-requester round-robin front end for a small registered ALU.
// One operation in flight: IDLE accepts, EXEC computes, RESP holds the result.
module alu_arb #(
    parameter int LEN = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [LEN-1:0] req0_a,
    input  logic [LEN-1:0] req0_b,
    input  logic [2:0]     req0_func,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [LEN-1:0] req1_a,
    input  logic [LEN-1:0] req1_b,
    input  logic [2:0]     req1_func,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [LEN-1:0] rsp_out,
    output logic           rsp_overflow,
    output logic           rsp_carry,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic           last_grant;
    logic           grant;
    logic [LEN-1:0] op_a;
    logic [LEN-1:0] op_b;
    logic [2:0]     op_func;
    logic           op_id;

    logic [LEN-1:0] b_x;
    logic [LEN:0]   sum;
    logic           sum_ovf;
    logic [LEN:0]   diff;
    logic           diff_ovf;
    logic           less;
    logic [LEN-1:0] alu_out;
    logic           alu_ovf;
    logic           alu_carry;

    // Tie goes to whoever did not win last; a lone valid requester always wins.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = req1_valid;
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. Requester readies are only offered in IDLE and never in reset;
    // the response side holds rsp_* stable until rsp_ready is seen.
    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state == IDLE) && req1_valid && grant;
    assign busy       = (state != IDLE);

    always_comb begin
        b_x      = op_b ^ {LEN{op_func[0]}};
        sum      = {1'b0, op_a} + {1'b0, b_x} + {{LEN{1'b0}}, op_func[0]};
        sum_ovf  = (op_a[LEN-1] == b_x[LEN-1]) && (sum[LEN-1] != op_a[LEN-1]);
        // Signed compare from the subtract path so it stays correct across overflow.
        diff     = {1'b0, op_a} + {1'b0, ~op_b} + {{LEN{1'b0}}, 1'b1};
        diff_ovf = (op_a[LEN-1] != op_b[LEN-1]) && (diff[LEN-1] != op_a[LEN-1]);
        less     = diff[LEN-1] ^ diff_ovf;

        alu_out   = '0;
        alu_ovf   = 1'b0;
        alu_carry = 1'b0;
        case (op_func)
            3'b000, 3'b001: begin
                alu_out   = sum[LEN-1:0];
                alu_ovf   = sum_ovf;
                alu_carry = sum[LEN];
            end
            3'b010:  alu_out = ~op_a;
            3'b011:  alu_out = op_a & op_b;
            3'b100:  alu_out = op_a | op_b;
            3'b101:  alu_out = op_a ^ op_b;
            3'b110:  alu_out = {{(LEN-1){1'b0}}, less};
            default: alu_out = {{(LEN-1){1'b0}}, (op_a == op_b)};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            op_a         <= '0;
            op_b         <= '0;
            op_func      <= '0;
            op_id        <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_out      <= '0;
            rsp_overflow <= 1'b0;
            rsp_carry    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        op_a       <= grant ? req1_a    : req0_a;
                        op_b       <= grant ? req1_b    : req0_b;
                        op_func    <= grant ? req1_func : req0_func;
                        op_id      <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_out      <= alu_out;
                    rsp_overflow <= alu_ovf;
                    rsp_carry    <= alu_carry;
                    rsp_id       <= op_id;
                    rsp_valid    <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
// Scoreboard bench for alu_arb: accepts push a modelled result, responses pop it.
module tb_alu_arb;

    localparam int LEN  = 4;
    localparam int SMAX = (1 << (LEN - 1)) - 1;
    localparam int SMIN = -(1 << (LEN - 1));
    localparam int MASK = (1 << LEN) - 1;
    localparam int EW   = LEN + 3;

    logic           clk;
    logic           rst_n;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [LEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]     req0_func, req1_func;
    logic           rsp_valid, rsp_ready, rsp_id;
    logic [LEN-1:0] rsp_out;
    logic           rsp_overflow, rsp_carry, busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] exp_q[$];

    int   cyc      = 0;
    int   acc_cyc  = 0;
    bit   fair_mode = 0;
    int   fair_cnt  = 0;

    alu_arb #(.LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry),
        .busy(busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference ALU from integer arithmetic: {id, out, overflow, carry}.
    function automatic logic [EW-1:0] model(input logic id, input logic [LEN-1:0] a,
                                            input logic [LEN-1:0] b, input logic [2:0] f);
        int sa, sb, ua, ub, r;
        logic [LEN-1:0] o;
        logic ov, cy;
        sa = $signed(a);
        sb = $signed(b);
        ua = int'(a);
        ub = int'(b);
        o  = '0;
        ov = 1'b0;
        cy = 1'b0;
        case (f)
            3'd0: begin
                r  = sa + sb;
                o  = r[LEN-1:0];
                ov = (r > SMAX) || (r < SMIN);
                cy = (ua + ub) > MASK;
            end
            3'd1: begin
                r  = sa - sb;
                o  = r[LEN-1:0];
                ov = (r > SMAX) || (r < SMIN);
                cy = (ua + (MASK - ub) + 1) > MASK;
            end
            3'd2: o = ~a;
            3'd3: o = a & b;
            3'd4: o = a | b;
            3'd5: o = a ^ b;
            3'd6: o = (sa < sb) ? LEN'(1) : '0;
            default: o = (a == b) ? LEN'(1) : '0;
        endcase
        return {id, o, ov, cy};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic           prev_valid, prev_stall, id;
        logic [EW-1:0]  e;
        logic [LEN-1:0] h_out;
        logic           h_id, h_ovf, h_cy;
        prev_valid = 0;
        prev_stall = 0;
        h_out = '0; h_id = 0; h_ovf = 0; h_cy = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 0;
                prev_stall = 0;
            end else begin
                cyc++;
                if (rsp_valid) begin
                    if (!prev_valid) check("latency", cyc - acc_cyc, 2);
                    check("resp_req_ready", {req0_ready, req1_ready}, 0);
                    check("resp_busy", busy, 1);
                    if (prev_stall) begin
                        check("hold_out", rsp_out, h_out);
                        check("hold_id", rsp_id, h_id);
                        check("hold_ovf", rsp_overflow, h_ovf);
                        check("hold_carry", rsp_carry, h_cy);
                    end
                    if (rsp_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rsp_unexpected", exp_q.size(), 1);
                        end else begin
                            e = exp_q.pop_front();
                            check("rsp_id", rsp_id, e[EW-1]);
                            check("rsp_out", rsp_out, e[LEN+1:2]);
                            check("rsp_overflow", rsp_overflow, e[1]);
                            check("rsp_carry", rsp_carry, e[0]);
                        end
                    end
                    h_out = rsp_out; h_id = rsp_id; h_ovf = rsp_overflow; h_cy = rsp_carry;
                end
                prev_stall = rsp_valid && !rsp_ready;
                prev_valid = rsp_valid;
                if (req0_ready || req1_ready) begin
                    check("ready_onehot", req0_ready & req1_ready, 0);
                    id = req1_ready;
                    if (id) exp_q.push_back(model(1'b1, req1_a, req1_b, req1_func));
                    else    exp_q.push_back(model(1'b0, req0_a, req0_b, req0_func));
                    if (fair_mode) begin
                        check("fair_grant", id, fair_cnt % 2);
                        if (fair_cnt > 0) check("fair_gap", cyc - acc_cyc, 3);
                        fair_cnt++;
                    end
                    acc_cyc = cyc;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic id, input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                        input logic [2:0] f);
        bit done;
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_func = f;
        end else begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_func = f;
        end
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if ((id && req1_ready) || (!id && req0_ready)) done = 1;
        end
        check("accept_timeout", done, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic wait_idle(input bit rnd);
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk); #1;
            rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (!busy && !rsp_valid) done = 1;
        end
        rsp_ready = 1;
        check("idle_timeout", done, 1);
    endtask

    task automatic fair_run(input int ncyc);
        fair_cnt  = 0;
        fair_mode = 1;
        @(posedge clk); #1;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < ncyc; i++) begin
            req0_a = LEN'($urandom_range(0, MASK)); req0_b = LEN'($urandom_range(0, MASK));
            req1_a = LEN'($urandom_range(0, MASK)); req1_b = LEN'($urandom_range(0, MASK));
            req0_func = 3'($urandom_range(0, 7));
            req1_func = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        fair_mode = 0;
        wait_idle(0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit done;
        rst_n = 0;
        rsp_ready = 1;
        req0_valid = 1; req1_valid = 1;
        req0_a = 4'h5; req0_b = 4'h3; req0_func = 3'd0;
        req1_a = 4'h9; req1_b = 4'h2; req1_func = 3'd1;
        #12;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_out", rsp_out, 0);
        check("rst_ovf", rsp_overflow, 0);
        check("rst_carry", rsp_carry, 0);
        check("rst_busy", busy, 0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        #5 rst_n = 1;

        // First tie after reset goes to requester 0, then strict alternation.
        fair_run(12);
        check("fair_count", fair_cnt, 4);

        // Directed operations.
        send(0, 4'b0111, 4'b0001, 3'b000); wait_idle(0);
        send(1, 4'b0011, 4'b0101, 3'b001); wait_idle(0);
        send(0, 4'b1000, 4'b0111, 3'b110); wait_idle(0);
        send(1, 4'b1010, 4'b1010, 3'b111); wait_idle(0);
        send(0, 4'b1010, 4'b0000, 3'b010); wait_idle(0);
        send(1, 4'b1100, 4'b1010, 3'b101); wait_idle(0);
        send(0, 4'b1111, 4'b0001, 3'b000); wait_idle(0);
        send(1, 4'b1000, 4'b0001, 3'b001); wait_idle(0);
        send(0, 4'b0111, 4'b1000, 3'b110); wait_idle(0);
        send(1, 4'b1100, 4'b0110, 3'b011); wait_idle(0);
        send(0, 4'b1100, 4'b0110, 3'b100); wait_idle(0);

        // Backpressure: hold RESP for 4 cycles with both requesters asking.
        rsp_ready = 0;
        send(1, 4'b0110, 4'b0011, 3'b001);
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (rsp_valid) done = 1;
        end
        check("bp_valid_timeout", done, 1);
        @(posedge clk); #1;
        req0_valid = 1; req1_valid = 1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 1;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        check("bp_still_resp", busy, 1);
        @(negedge clk);
        check("bp_idle_busy", busy, 0);
        check("bp_idle_valid", rsp_valid, 0);

        // Random traffic with random response backpressure.
        for (int i = 0; i < 25; i++) begin
            send(1'($urandom_range(0, 1)), LEN'($urandom_range(0, MASK)),
                 LEN'($urandom_range(0, MASK)), 3'($urandom_range(0, 7)));
            wait_idle(1);
        end

        // Reset while in EXEC discards the operation.
        send(0, 4'b0101, 4'b0110, 3'b000);
        check("midrst_busy_before", busy, 1);
        rst_n = 0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_out", rsp_out, 0);
        check("midrst_rsp_id", rsp_id, 0);
        check("midrst_flags", {rsp_overflow, rsp_carry}, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", {req0_ready, req1_ready}, 0);
        exp_q.delete();
        #12 rst_n = 1;
        repeat (6) @(negedge clk);
        check("midrst_no_rsp", rsp_valid, 0);
        check("midrst_idle", busy, 0);

        // Grant pointer restored by reset: tie goes to 0 again.
        fair_run(6);
        check("fair2_count", fair_cnt, 2);
        send(1, 4'b0010, 4'b0011, 3'b000); wait_idle(0);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 The block SHALL have one parameter: LEN, default 4, operand/result width in bits.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 The block SHALL have these ports, in order:
  clk  input  1  clock, all state on rising edge
  rst_n  input  1  asynchronous active-low reset
  req0_valid  input  1  requester 0 has an operation
  req0_ready  output  1  requester 0 operation accepted this cycle
  req0_a, req0_b  input  LEN  requester 0 operands, two's complement
  req0_func  input  3  requester 0 opcode
  req1_valid, req1_ready, req1_a, req1_b, req1_func  as req0_*, for requester 1
  rsp_valid  output  1  result available
  rsp_ready  input  1  consumer takes result
  rsp_id  output  1  requester that owns the result
  rsp_out  output  LEN  result
  rsp_overflow  output  1  signed overflow flag
  rsp_carry  output  1  adder carry-out flag
  busy  output  1  high in every state except IDLE

Function
REQ-004 The FSM SHALL have states IDLE, EXEC and RESP; there SHALL be one transaction in flight at most.
REQ-005 In IDLE, exactly one reqN_ready SHALL be high when its reqN_valid is high and it holds the grant; otherwise both SHALL be low; outside IDLE both SHALL be low.
REQ-006 Grant: if only one requester is valid, it SHALL win. If both are valid, the requester not granted most recently SHALL win. The last-grant pointer SHALL reset so that requester 0 wins the first tie.
REQ-007 On the accept edge (IDLE, reqN_valid and reqN_ready high), a, b, func and id SHALL be latched, the last-grant pointer SHALL be updated, and the FSM SHALL go to EXEC.
REQ-008 In EXEC the ALU result and flags SHALL be computed from the latched operands and registered into rsp_*; the FSM SHALL go to RESP unconditionally.
REQ-009 In RESP, rsp_valid SHALL be high. The FSM SHALL leave for IDLE on the edge where rsp_ready is high.
REQ-010 Latency SHALL be fixed: rsp_valid rises 2 cycles after the accept edge. Back-to-back throughput SHALL be one operation per 3 cycles. There SHALL be no IDLE bypass.
REQ-011 While rsp_valid is high and rsp_ready is low, rsp_out, rsp_id and the flags SHALL hold stable.
REQ-012 Opcodes (a, b are LEN-bit two's complement):
  000 a+b
  001 a-b, computed as a+~b+1
  010 ~a
  011 a&b
  100 a|b
  101 a^b
  110 signed a<b, zero-extended to LEN
  111 a==b, zero-extended to LEN
REQ-013 For 000/001, rsp_carry SHALL be bit LEN of the (LEN+1)-bit sum a+(b XOR {LEN{func[0]}})+func[0], and rsp_overflow SHALL be signed overflow of that sum. For all other opcodes, both flags SHALL be 0.
REQ-014 Opcode 110 SHALL be evaluated as sign(a-b) XOR overflow(a-b), so it is correct across overflow.
REQ-015 Input changes outside the accept edge SHALL have no effect on an in-flight transaction.

Reset
REQ-016 While rst_n is low, regardless of clk, the following SHALL hold:
  state = IDLE
  last-grant pointer selects requester 0 on the first tie
  rsp_valid, rsp_id, rsp_out, rsp_overflow, rsp_carry, busy = 0
  req0_ready, req1_ready = 0
REQ-017 Reset asserted in EXEC or RESP SHALL discard the transaction; no response SHALL appear after rst_n deasserts.

Verification
REQ-018 Add overflow, LEN=4: req0 a=0111, b=0001, func=000 -> rsp_out=1000, rsp_overflow=1, rsp_carry=0, rsp_id=0, rsp_valid 2 cycles after accept.
REQ-019 Subtract: req1 a=0011, b=0101, func=001 -> rsp_out=1110, rsp_carry=0, rsp_overflow=0, rsp_id=1. Compare: a=1000, b=0111, func=110 -> rsp_out=0001, flags 0.
REQ-020 Equality and logic: a=b=1010, func=111 -> 0001; func=010 with a=1010 -> 0101; func=101 with a=1100, b=1010 -> 0110.
REQ-021 Fairness: both requesters valid continuously, rsp_ready tied high -> grants alternate 0,1,0,1 starting with 0; each accept is 3 cycles after the previous one.
REQ-022 Backpressure: rsp_ready held low 4 cycles in RESP -> rsp_* stable, both req readies low, busy=1; rsp_ready high -> IDLE on the next edge.
REQ-023 Reset mid-operation: rst_n pulsed low in EXEC -> all outputs 0 immediately; after release, no rsp_valid until a new accept.
